mod_mul_seq: RTL and testbench
==============================

MOD_MUL_SEQ -- requirements
Module: mod_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand, modulus and result width in bits.
REQ-002 SHALL have parameter MOD, default 998244353, the odd modulus; MOD < 2^(WIDTH-1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 SHALL have port mode  input  1  0 = plain a*b mod MOD; 1 = Montgomery product a*b*R^-1 mod MOD, where R = 2^WIDTH.
REQ-008 SHALL have ports a, b  input  WIDTH  operands, sampled with mode on the accept edge.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  WIDTH  registered result, always < MOD when valid.

Function
REQ-012 SHALL accept a transaction on a rising edge where in_valid && in_ready are both high.
REQ-013 SHALL use FSM states IDLE, RED1, RED2 and DONE.
REQ-014 SHALL transition IDLE->RED1 on accept; RED1->DONE if mode=1, else RED1->RED2; RED2->DONE.
REQ-015 SHALL transition DONE->IDLE on out_ready with no new accept, and DONE->RED1 on out_ready with a simultaneous accept.
REQ-016 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-017 SHALL define REDC(x,y) as: T = x*y (2*WIDTH bits); m = (T mod R)*NPRIME mod R; t = (T + m*MOD) >> WIDTH, computed in 2*WIDTH+1 bits; subtract MOD once if t >= MOD.
REQ-018 SHALL register t1 = REDC(a,b) in RED1 and result = REDC(t1,R2) in RED2; in mode 1, result = t1.
REQ-019 SHALL reach latency from the accept edge E0 to visible out_valid of 1 edge for mode 1 and 2 edges for mode 0.
REQ-020 SHALL hold out_valid and result stable in DONE until out_ready is high, with no drop and no change under backpressure.
REQ-021 SHALL sustain back-to-back throughput of one operation per 2 cycles in mode 1 and per 3 cycles in mode 0.
REQ-022 SHALL leave result unspecified when an operand is >= MOD and MOD_MUL_ERR_EN is undefined.

Reset
REQ-023 SHALL, on rst_n low, immediately set state=IDLE, out_valid=0, result=0, t1=0 and out_err=0, regardless of clock.
REQ-024 SHALL discard any in-flight operation on reset and SHALL NOT emit it after reset release.
REQ-025 SHALL drive in_ready=1 in the first cycle after reset release.

Configuration
REQ-026 SHALL add, with macro MOD_MUL_ERR_EN defined, port out_err  output  1, valid with out_valid, set when a >= MOD or b >= MOD at accept, with result forced to 0 and latency unchanged.
REQ-027 SHALL have no out_err port and no range comparators when MOD_MUL_ERR_EN is undefined.

Structure
REQ-028 SHALL place in package mod_mul_pkg: the FSM state enum; constant functions calc_nprime(WIDTH,MOD) = -MOD^-1 mod 2^WIDTH (998244351 for the defaults) and calc_r2(WIDTH,MOD) = 2^(2*WIDTH) mod MOD.
REQ-029 SHALL derive NPRIME and R2 as localparams at elaboration and SHALL fail elaboration via $error if MOD is even.
REQ-030 SHALL instantiate one combinational sub-module mont_redc_core (x, y -> REDC), reused by RED1 and RED2 through an operand mux.

Verification
REQ-031 SHALL cover plain mode with a=2, b=3 -> result=6, out_valid exactly 2 edges after accept.
REQ-032 SHALL cover plain mode with a=b=998244352 -> 1, and with a=0, b=123456 -> 0.
REQ-033 SHALL cover mode 1 with a=301989884 (R mod MOD), b=5 -> 5, out_valid 1 edge after accept.
REQ-034 SHALL cover backpressure: out_ready held low for 5 cycles -> result and out_valid stable, in_ready=0; then out_ready=1 together with a new in_valid -> accepted the same edge.
REQ-035 SHALL cover rst_n pulsed low while in RED2 -> out_valid=0 and result=0 at once, with no stale output after release.
REQ-036 SHALL cover 1000 random in-range pairs in both modes against a software model, plus, with MOD_MUL_ERR_EN, a=MOD -> out_err=1 and result=0.

Source files
------------

// File: rtl/mod_mul_pkg.sv
// Shared state encoding and elaboration-time Montgomery constants for mod_mul_seq.
package mod_mul_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned CALC_W  = 128;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RED1 = 2'd1;
    localparam state_t RED2 = 2'd2;
    localparam state_t DONE = 2'd3;

    // -modulus^-1 mod 2^width via Newton iteration; each step doubles the correct low bits.
    function automatic longint unsigned calc_nprime(input int unsigned width,
                                                    input longint unsigned modulus);
        logic [CALC_W-1:0] mask;
        logic [CALC_W-1:0] m;
        logic [CALC_W-1:0] inv;
        mask = (CALC_W'(1) << width) - CALC_W'(1);
        m    = CALC_W'(modulus);
        inv  = CALC_W'(1);
        for (int i = 0; i < 7; i++) begin
            inv = (inv * ((CALC_W'(2) - m * inv) & mask)) & mask;
        end
        return 64'((~inv + CALC_W'(1)) & mask);
    endfunction

    // 2^(2*width) mod modulus by repeated doubling.
    function automatic longint unsigned calc_r2(input int unsigned width,
                                                input longint unsigned modulus);
        logic [CALC_W-1:0] r;
        logic [CALC_W-1:0] m;
        m = CALC_W'(modulus);
        r = CALC_W'(1);
        for (int unsigned i = 0; i < 2 * width; i++) begin
            r = r << 1;
            if (r >= m) begin
                r = r - m;
            end
        end
        return 64'(r);
    endfunction

endpackage

// File: rtl/mod_mul_seq_redc.sv
// Combinational Montgomery reduction: z_c = x*y*2^-WIDTH mod MOD for x, y < MOD.
module mont_redc_core #(
    parameter int unsigned       WIDTH  = 32,
    parameter logic [WIDTH-1:0]  MOD    = WIDTH'(998244353),
    parameter logic [WIDTH-1:0]  NPRIME = WIDTH'(998244351)
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z_c
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = 2 * WIDTH + 1;

    logic [PW-1:0]    prod_c;
    logic [WIDTH-1:0] m_c;
    logic [SW-1:0]    sum_c;
    logic [WIDTH:0]   t_c;

    assign prod_c = PW'(x) * PW'(y);
    // Low WIDTH bits of the product are all that matter for m (mod R).
    assign m_c    = prod_c[WIDTH-1:0] * NPRIME;
    assign sum_c  = SW'(prod_c) + SW'(m_c) * SW'(MOD);
    assign t_c    = (WIDTH+1)'(sum_c >> WIDTH);
    // t < 2*MOD, so one conditional subtraction lands in [0, MOD).
    assign z_c    = (t_c >= (WIDTH+1)'(MOD)) ? WIDTH'(t_c - (WIDTH+1)'(MOD)) : WIDTH'(t_c);

endmodule

// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier (plain or Montgomery) sharing one REDC core across two passes.
// Optional operand range checking with out_err is enabled by defining MOD_MUL_ERR_EN.
module mod_mul_seq
    import mod_mul_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter longint unsigned  MOD   = 64'd998244353
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef MOD_MUL_ERR_EN
    ,
    output logic             out_err
`endif
);

    localparam logic [WIDTH-1:0] MOD_W  = WIDTH'(MOD);
    localparam logic [WIDTH-1:0] NPRIME = WIDTH'(calc_nprime(WIDTH, MOD));
    localparam logic [WIDTH-1:0] R2     = WIDTH'(calc_r2(WIDTH, MOD));

    if ((MOD % 64'd2) == 64'd0) begin : g_even_mod
        $error("mod_mul_seq: MOD must be odd");
    end
    if ((MOD >> (WIDTH - 1)) != 64'd0) begin : g_big_mod
        $error("mod_mul_seq: MOD must be below 2^(WIDTH-1)");
    end

    state_t           state;
    state_t           state_d;
    logic             accept_c;
    logic             load_c;
    logic             op_err_c;
    logic             mode_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] t1;
    logic [WIDTH-1:0] redc_x_c;
    logic [WIDTH-1:0] redc_y_c;
    logic [WIDTH-1:0] redc_z_c;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept_c = in_valid && in_ready;
    // Result is captured at the end of the final reduction pass for the selected mode.
    assign load_c   = ((state == RED1) && mode_q) || (state == RED2);

    // Second pass converts out of Montgomery form: REDC(t1, R^2) = a*b mod MOD.
    assign redc_x_c = (state == RED2) ? t1 : a_q;
    assign redc_y_c = (state == RED2) ? R2 : b_q;

    mont_redc_core #(
        .WIDTH  (WIDTH),
        .MOD    (MOD_W),
        .NPRIME (NPRIME)
    ) u_redc (
        .x   (redc_x_c),
        .y   (redc_y_c),
        .z_c (redc_z_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept_c) state_d = RED1;
            RED1:    state_d = mode_q ? DONE : RED2;
            RED2:    state_d = DONE;
            DONE:    if (out_ready) state_d = accept_c ? RED1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // out_valid mirrors the DONE state one edge early so it is a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_d == DONE);
        end
    end

    // Operand capture and reduction results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            t1     <= '0;
            result <= '0;
        end else begin
            if (accept_c) begin
                a_q    <= a;
                b_q    <= b;
                mode_q <= mode;
            end
            if (state == RED1) begin
                t1 <= redc_z_c;
            end
            if (load_c) begin
                result <= op_err_c ? '0 : redc_z_c;
            end
        end
    end

`ifdef MOD_MUL_ERR_EN
    logic err_q;

    // Range flag captured with the operands, reported alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            out_err <= 1'b0;
        end else begin
            if (accept_c) begin
                err_q <= (a >= MOD_W) || (b >= MOD_W);
            end
            if (load_c) begin
                out_err <= err_q;
            end
        end
    end

    assign op_err_c = err_q;
`else
    assign op_err_c = 1'b0;
`endif

endmodule

// File: tb/tb_mod_mul_seq.sv
// Randomized self-checking bench for mod_mul_seq against an arithmetic reference model.
module tb_mod_mul_seq;

    localparam int unsigned     WIDTH = 32;
    localparam longint unsigned M     = 64'd998244353;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
`ifdef MOD_MUL_ERR_EN
    logic             out_err;
`endif

    int              errors = 0;
    int              checks = 0;
    longint          cyc = 0;
    bit              rdy_force0 = 1'b0;
    bit              rdy_rand = 1'b0;
    longint unsigned rinv = 0;

    typedef struct {
        longint unsigned val;
        bit              err;
        longint          acc;
        longint          lat;
    } exp_t;

    exp_t exp_q[$];

    mod_mul_seq #(.WIDTH(WIDTH), .MOD(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef MOD_MUL_ERR_EN
        ,
        .out_err   (out_err)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: always ready, randomly ready, or stalled by the directed tests.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_force0)    out_ready = 1'b0;
            else if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
            else               out_ready = 1'b1;
        end
    end

    function automatic longint unsigned mulmod(input longint unsigned x, input longint unsigned y);
        return (x * y) % M;
    endfunction

    function automatic longint unsigned powmod(input longint unsigned base, input longint unsigned e);
        longint unsigned r = 1;
        longint unsigned bb = base % M;
        while (e != 0) begin
            if (e[0]) r = mulmod(r, bb);
            bb = mulmod(bb, bb);
            e  = e >> 1;
        end
        return r;
    endfunction

    function automatic longint unsigned model_val(input longint unsigned x, input longint unsigned y,
                                                  input bit m);
        return m ? mulmod(mulmod(x, y), rinv) : mulmod(x, y);
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Compare process: every cycle the DUT is held against the queue of expected results.
    always @(negedge clk) begin
        bit   done;
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            chk("reset_out_valid", out_valid, 0);
            chk("reset_result", result, 0);
`ifdef MOD_MUL_ERR_EN
            chk("reset_out_err", out_err, 0);
`endif
        end else begin
            done = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + exp_q[0].lat);
            chk("out_valid", out_valid, done);
            chk("in_ready", in_ready, (exp_q.size() == 0) || (done && out_ready));
            if (done && out_valid) begin
                chk("result", result, exp_q[0].val);
`ifdef MOD_MUL_ERR_EN
                chk("out_err", out_err, exp_q[0].err);
`endif
            end
            if (done && out_ready) void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                e.err = 1'b0;
`ifdef MOD_MUL_ERR_EN
                e.err = (longint'(a) >= M) || (longint'(b) >= M);
`endif
                e.val = e.err ? 0 : model_val(a, b, mode);
                e.acc = cyc + 1;
                e.lat = mode ? 1 : 2;
                exp_q.push_back(e);
            end
        end
    end

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    // Present an operand pair from a posedge+1 phase; returns just after the accept edge.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic m,
                        output longint acc, output int waits);
        a = av; b = bv; mode = m; in_valid = 1'b1; waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 100) begin
                errors++; checks++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", waits);
                summary();
                $fatal(1, "stalled");
            end
        end
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic wait_valid(input longint acc, output longint lat);
        int n = 0;
        lat = -1;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - acc;
                break;
            end
            n++;
            if (n > 20) begin
                errors++; checks++;
                $display("FAIL valid_timeout: out_valid low for %0d cycles, required 1", n);
                break;
            end
        end
    endtask

    task automatic lit(input string name, input logic [31:0] av, input logic [31:0] bv,
                       input logic m, input longint unsigned expv, input longint explat);
        longint acc;
        longint lat;
        int     w;
        send(av, bv, m, acc, w);
        in_valid = 1'b0;
        wait_valid(acc, lat);
        chk({name, "_lat"}, lat, explat);
        chk({name, "_res"}, result, expv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        longint acc0, acc1, acc2, lat;
        int     w;
        logic [31:0] ra, rb;
        logic        rm;

        rinv = powmod((64'd1 << 32) % M, M - 2);
        chk("model_plain", model_val(2, 3, 0), 6);
        chk("model_mont", model_val(301989884, 5, 1), 5);
        chk("model_neg1", model_val(M - 1, M - 1, 0), 1);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        lit("plain_2x3", 2, 3, 0, 6, 2);
        lit("plain_neg1", 32'(M - 1), 32'(M - 1), 0, 1, 2);
        lit("plain_zero", 0, 123456, 0, 0, 2);
        lit("mont_r", 301989884, 5, 1, 5, 1);

        // Back-to-back throughput in each mode.
        send(1, 2, 1, acc0, w);
        send(3, 4, 1, acc1, w);
        send(5, 6, 1, acc2, w);
        in_valid = 1'b0;
        chk("tput_mont_1", acc1 - acc0, 2);
        chk("tput_mont_2", acc2 - acc1, 2);
        repeat (4) @(posedge clk);
        #1;
        send(7, 8, 0, acc0, w);
        send(9, 10, 0, acc1, w);
        send(11, 12, 0, acc2, w);
        in_valid = 1'b0;
        chk("tput_plain_1", acc1 - acc0, 3);
        chk("tput_plain_2", acc2 - acc1, 3);
        repeat (5) @(posedge clk);
        #1;

        // Backpressure: result must hold, then release coincides with a new accept.
        rdy_force0 = 1'b1;
        send(7, 9, 0, acc0, w);
        in_valid = 1'b0;
        wait_valid(acc0, lat);
        chk("bp_lat", lat, 2);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_result", result, 63);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        rdy_force0 = 1'b0;
        send(11, 13, 0, acc1, w);
        in_valid = 1'b0;
        chk("bp_same_edge_accept", w, 0);
        wait_valid(acc1, lat);
        chk("bp_next_lat", lat, 2);
        chk("bp_next_res", result, 143);
        @(posedge clk);
        #1;

        // Reset while the second reduction pass is in progress.
        send(100, 200, 0, acc0, w);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_result", result, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;

`ifdef MOD_MUL_ERR_EN
        lit("err_a_mod", 32'(M), 5, 0, 0, 2);
        chk("err_flag", out_err, 1);
        lit("err_b_mod", 3, 32'(M + 7), 1, 0, 1);
        chk("err_flag_m1", out_err, 1);
`endif

        // Random operands, both modes, with idle gaps and (later) random backpressure.
        for (int i = 0; i < 1000; i++) begin
            rdy_rand = (i >= 500);
            ra = 32'($urandom_range(0, 32'(M - 1)));
            rb = 32'($urandom_range(0, 32'(M - 1)));
            if ($urandom_range(0, 19) == 0) ra = 32'(M - 1);
            if ($urandom_range(0, 19) == 0) rb = 0;
`ifdef MOD_MUL_ERR_EN
            if ($urandom_range(0, 15) == 0) ra = 32'(M) + 32'($urandom_range(0, 1000));
`endif
            rm = 1'($urandom_range(0, 1));
            send(ra, rb, rm, acc0, w);
            if ($urandom_range(0, 2) != 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        rdy_rand = 1'b0;
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
        chk("drain_empty", exp_q.size(), 0);

        summary();
        $finish;
    end

endmodule
